// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding a single UART transmitter via a ready/valid/busy handshake.
// Optional message lock (whole message per requester) enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IW-1:0]        last_grant;
    logic [NUM_REQ-1:0]   eligible;
    logic [IW-1:0]        winner;
    logic [IW-1:0]        cand;
    logic                 found;
    logic                 accept;

`ifdef UART_TX_ARB_LOCK_EN
    logic          locked;
    logic [IW-1:0] lock_owner;

    always_comb begin
        eligible = req_valid;
        if (locked) eligible = req_valid & (NUM_REQ'(1) << lock_owner);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked     <= 1'b0;
            lock_owner <= '0;
        end else if (accept) begin
            locked     <= !req_last[winner];
            lock_owner <= winner;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign eligible    = req_valid;
`endif

    // First eligible requester strictly after last_grant, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((32'(last_grant) + i) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign accept = (state == IDLE) && tx_ready && found && !rst;
    assign busy   = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (accept) state_next = ISSUE;
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready) state_next = WAIT_DONE;
            WAIT_DONE: if (tx_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= IW'(NUM_REQ - 1);
        end else begin
            tx_valid <= accept;
            if (accept) begin
                tx_data  <= req_data[8*winner +: 8];
                grant_id <= winner;
            end
            if (state == WAIT_DONE && tx_ready) last_grant <= grant_id;
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one parameter: NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 The block SHALL have clk, input, 1, clock.
REQ-003 The block SHALL have rst, input, 1, reset: asynchronous, active-high.
REQ-004 The block SHALL have req_valid, input, NUM_REQ, per-requester byte available.
REQ-005 The block SHALL have req_data, input, NUM_REQ*8, byte of requester i at bits [8i+7:8i].
REQ-006 The block SHALL have req_last, input, NUM_REQ, byte is the last of its message (lock mode only).
REQ-007 The block SHALL have req_ready, output, NUM_REQ, one-hot single-cycle accept pulse.
REQ-008 The block SHALL have tx_ready, input, 1, UART transmitter ready (transmitter's o_ready).
REQ-009 The block SHALL have tx_data, output, 8, byte to transmitter.
REQ-010 The block SHALL have tx_valid, output, 1, start pulse to transmitter.
REQ-011 The block SHALL have grant_id, output, $clog2(NUM_REQ), index of the current or last granted requester.
REQ-012 The block SHALL have busy, output, 1, high in every state except IDLE.

Function
REQ-013 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
REQ-014 In IDLE, with tx_ready=1 and any eligible req_valid, the block SHALL select a winner round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-015 In that same cycle the block SHALL drive req_ready[winner]=1 (a transfer happens when req_valid & req_ready), latch req_data[winner] into tx_data, set grant_id=winner, and move to ISSUE.
REQ-016 In IDLE with tx_ready=0, the block SHALL accept nothing and keep every req_ready low.
REQ-017 In ISSUE, tx_valid SHALL be 1 for exactly one cycle with tx_data stable, and the FSM SHALL go to WAIT_BUSY.
REQ-018 In WAIT_BUSY, the block SHALL wait for tx_ready=0, then go to WAIT_DONE.
REQ-019 In WAIT_DONE, the block SHALL wait for tx_ready=1, then go to IDLE and set last_grant=grant_id.
REQ-020 tx_valid SHALL be registered, and SHALL never be high outside ISSUE.
REQ-021 req_ready SHALL be at most one-hot, and SHALL be high only in the IDLE accept cycle.
REQ-022 tx_data SHALL hold its value from the accept cycle until the next accept.
REQ-023 Minimum spacing between consecutive accepts SHALL be 4 cycles plus the transmitter busy time.
REQ-024 A requester that deasserts req_valid before it is granted SHALL lose nothing; the block SHALL keep no per-requester state other than the lock owner.
REQ-025 When several requesters are valid at the same time, exactly one SHALL be granted per accept, and with all valid the grant order after reset SHALL be 0,1,...,NUM_REQ-1,0.

Reset
REQ-026 On rst, the FSM SHALL go to IDLE with: tx_valid=0, tx_data=0, req_ready=0, busy=0, grant_id=0, last_grant=NUM_REQ-1, lock released.
REQ-027 Reset mid-transfer SHALL abandon the transfer with no further tx_valid; the transmitter is reset by the same rst.

Configuration
REQ-028 With UART_TX_ARB_LOCK_EN defined, once a requester is accepted with req_last=0, IDLE SHALL consider only that requester until a byte with req_last=1 is accepted; then the lock SHALL be released and round-robin SHALL resume from that requester+1.
REQ-029 While locked with the owner's req_valid=0, the block SHALL stay in IDLE and grant no other requester.
REQ-030 Without UART_TX_ARB_LOCK_EN, req_last SHALL be ignored, arbitration SHALL be per byte, and no lock register SHALL exist.

Verification
REQ-031 Single request: NUM_REQ=4, tx_ready=1, req_valid=4'b0100 with byte 0x5A -> req_ready=4'b0100 for one cycle; tx_valid pulse the next cycle with tx_data=0x5A; grant_id=2.
REQ-032 Fairness: all four valid continuously, bytes 0x10+i -> tx_data sequence 0x10,0x11,0x12,0x13,0x10; no accept while busy=1.
REQ-033 Backpressure: tx_ready held 0 for 20 cycles while req_valid=4'b0001 -> no req_ready and no tx_valid until tx_ready=1.
REQ-034 Handshake with a real uart_transmitter (BIT_TIME=4): two bytes 0xA5 then 0x3C from requester 1 -> two complete frames, no overlap, tx_valid only while o_ready=1.
REQ-035 Lock (macro defined): requester 0 sends 3 bytes with req_last on the third while requester 3 is valid -> order 0,0,0,3. Same stimulus without the macro -> order 0,3,0,3,0.
REQ-036 Reset while in WAIT_DONE -> next cycle all outputs at reset values; first grant after release goes to requester 0.
